// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and counter sizing for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN
    } state_e;

    localparam int RETRY_CNT_W = 8;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for bringing asynchronous levels into the clk_i domain.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, qualifies LOCKED, then releases domain resets in turn.
// Define PLL_SEQ_RETRY_EN to re-pulse the PLL after a lock timeout and count the retries.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 200000,
    parameter int DOMAIN_STAGGER      = 8,
    parameter int NUM_DOMAINS         = 2
) (
    input  logic                   sysclk_i,
    input  logic                   rst_i,
    input  logic                   pll_locked_i,
    output logic                   pll_rst_o,
    output logic [NUM_DOMAINS-1:0] domain_rst_o,
    output logic                   ready_o,
    output logic                   lock_lost_o,
    output logic [RETRY_CNT_W-1:0] retry_cnt_o
);

    localparam int HW  = cnt_w(RST_HOLD_CYCLES);
    localparam int SBW = cnt_w(LOCK_STABLE_CYCLES);
    localparam int GW  = cnt_w(DOMAIN_STAGGER);
    localparam logic [HW-1:0]  HOLD_LAST   = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [SBW-1:0] STABLE_DONE = SBW'(LOCK_STABLE_CYCLES);
    localparam logic [GW-1:0]  STG_LAST    = GW'(DOMAIN_STAGGER - 1);

    state_e                 state_q;
    logic [HW-1:0]          hold_q;
    logic [SBW-1:0]         stable_q;
    logic [GW-1:0]          stg_q;
    logic                   pll_rst_q;
    logic [NUM_DOMAINS-1:0] dom_q;
    logic [NUM_DOMAINS-1:0] dom_d;
    logic                   ready_q;
    logic                   lost_q;
    logic                   lk_s;

`ifdef PLL_SEQ_RETRY_EN
    localparam int TW = cnt_w(LOCK_TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    logic [TW-1:0]          to_q;
    logic [RETRY_CNT_W-1:0] retry_q;
    assign retry_cnt_o = retry_q;
`else
    assign retry_cnt_o = '0;
`endif

    sync_2ff #(.W(1)) u_lock_sync (
        .clk_i (sysclk_i),
        .rst_i (rst_i),
        .d_i   (pll_locked_i),
        .q_o   (lk_s)
    );

    // Bit 0 releases first: each shift clears the next-higher reset bit.
    assign dom_d = dom_q << 1;

    always_ff @(posedge sysclk_i) begin
        lost_q <= 1'b0;
        if (rst_i) begin
            state_q   <= S_RESET;
            hold_q    <= '0;
            stable_q  <= '0;
            stg_q     <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '1;
            ready_q   <= 1'b0;
`ifdef PLL_SEQ_RETRY_EN
            to_q      <= '0;
            retry_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_RESET: begin
`ifdef PLL_SEQ_RETRY_EN
                    to_q <= '0;
`endif
                    if (hold_q == HOLD_LAST) begin
                        state_q   <= S_WAIT_LOCK;
                        pll_rst_q <= 1'b0;
                        hold_q    <= '0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                S_WAIT_LOCK, S_STABLE: begin
`ifdef PLL_SEQ_RETRY_EN
                    to_q <= to_q + 1'b1;
                    if (to_q == TO_LAST) begin
                        state_q   <= S_RESET;
                        pll_rst_q <= 1'b1;
                        stable_q  <= '0;
                        if (retry_q != '1) retry_q <= retry_q + 1'b1;
                    end else
`endif
                    if (state_q == S_WAIT_LOCK) begin
                        if (lk_s) begin
                            state_q  <= S_STABLE;
                            stable_q <= SBW'(1);
                        end
                    end else if (!lk_s) begin
                        state_q  <= S_WAIT_LOCK;
                        stable_q <= '0;
                    end else if (stable_q == STABLE_DONE) begin
                        state_q <= (dom_d == '0) ? S_RUN : S_RELEASE;
                        ready_q <= (dom_d == '0);
                        dom_q   <= dom_d;
                        stg_q   <= '0;
                    end else begin
                        stable_q <= stable_q + 1'b1;
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (!lk_s) begin
                        state_q   <= S_RESET;
                        hold_q    <= '0;
                        pll_rst_q <= 1'b1;
                        dom_q     <= '1;
                        ready_q   <= 1'b0;
                        lost_q    <= 1'b1;
                    end else if (state_q == S_RELEASE) begin
                        if (stg_q == STG_LAST) begin
                            stg_q   <= '0;
                            dom_q   <= dom_d;
                            ready_q <= (dom_d == '0);
                            state_q <= (dom_d == '0) ? S_RUN : S_RELEASE;
                        end else begin
                            stg_q <= stg_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_RESET;
            endcase
        end
    end

    assign pll_rst_o    = pll_rst_q;
    assign domain_rst_o = dom_q;
    assign ready_o      = ready_q;
    assign lock_lost_o  = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed checks of PLL reset pulse, lock qualification, staggered release,
// lock loss, reset priority and (with PLL_SEQ_RETRY_EN) timeout retries.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b1;
    logic       pll_rst;
    logic [2:0] dom;
    logic       ready;
    logic       lost;
    logic [7:0] retry;
    int         n_chk = 0;
    int         n_fail = 0;

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES     (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .DOMAIN_STAGGER      (2),
        .NUM_DOMAINS         (3)
    ) dut (
        .sysclk_i     (clk),
        .rst_i        (rst),
        .pll_locked_i (locked),
        .pll_rst_o    (pll_rst),
        .domain_rst_o (dom),
        .ready_o      (ready),
        .lock_lost_o  (lost),
        .retry_cnt_o  (retry)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts just after the edge that entered S_RESET, with the PLL locked.
    task automatic seq(input string tag);
        step(1);
        chk({tag, " lost cleared"}, lost, 0);
        chk({tag, " pll_rst r1"}, pll_rst, 1);
        step(2);
        chk({tag, " pll_rst r3"}, pll_rst, 1);
        chk({tag, " dom r3"}, dom, 3'b111);
        step(1);
        chk({tag, " pll_rst fall"}, pll_rst, 0);
        step(8);
        chk({tag, " dom r12"}, dom, 3'b111);
        chk({tag, " ready r12"}, ready, 0);
        step(1);
        chk({tag, " dom r13"}, dom, 3'b110);
        chk({tag, " ready r13"}, ready, 0);
        step(1);
        chk({tag, " dom r14"}, dom, 3'b110);
        step(1);
        chk({tag, " dom r15"}, dom, 3'b100);
        step(1);
        chk({tag, " dom r16"}, dom, 3'b100);
        chk({tag, " ready r16"}, ready, 0);
        step(1);
        chk({tag, " dom r17"}, dom, 3'b000);
        chk({tag, " ready r17"}, ready, 1);
        chk({tag, " retry"}, retry, 0);
    endtask

    initial begin
        step(3);
        chk("reset pll_rst", pll_rst, 1);
        chk("reset dom", dom, 3'b111);
        chk("reset ready", ready, 0);
        chk("reset lost", lost, 0);
        chk("reset retry", retry, 0);
        rst = 1'b0;
        seq("t1");

        locked = 1'b0;
        step(2);
        chk("t3 ready before react", ready, 1);
        chk("t3 dom before react", dom, 3'b000);
        step(1);
        chk("t3 dom", dom, 3'b111);
        chk("t3 ready", ready, 0);
        chk("t3 pll_rst", pll_rst, 1);
        chk("t3 lost", lost, 1);
        chk("t3 retry", retry, 0);
        locked = 1'b1;
        seq("t3 reseq");

        rst = 1'b1;
        step(1);
        chk("t2 midop dom", dom, 3'b111);
        chk("t2 midop ready", ready, 0);
        chk("t2 midop pll_rst", pll_rst, 1);
        rst = 1'b0;
        step(7);
        locked = 1'b0;
        step(3);
        locked = 1'b1;
        chk("t2 pll_rst glitch", pll_rst, 0);
        step(3);
        chk("t2 dom r13", dom, 3'b111);
        chk("t2 pll_rst r13", pll_rst, 0);
        step(7);
        chk("t2 dom r20", dom, 3'b111);
        step(1);
        chk("t2 dom r21", dom, 3'b110);
        step(4);
        chk("t2 dom r25", dom, 3'b000);
        chk("t2 ready r25", ready, 1);
        chk("t2 retry", retry, 0);

        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(15);
        chk("t6 dom before rst", dom, 3'b100);
        rst = 1'b1;
        step(1);
        chk("t6 dom", dom, 3'b111);
        chk("t6 pll_rst", pll_rst, 1);
        chk("t6 lost", lost, 0);
        chk("t6 ready", ready, 0);
        rst = 1'b0;
        seq("t6 recovery");

        locked = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
`ifdef PLL_SEQ_RETRY_EN
        step(35);
        chk("t4 pll_rst r35", pll_rst, 0);
        chk("t4 retry r35", retry, 0);
        step(1);
        chk("t4 pll_rst r36", pll_rst, 1);
        chk("t4 retry r36", retry, 1);
        step(3);
        chk("t4 pll_rst r39", pll_rst, 1);
        step(1);
        chk("t4 pll_rst r40", pll_rst, 0);
        step(32);
        chk("t4 pll_rst r72", pll_rst, 1);
        chk("t4 retry r72", retry, 2);
        step(36);
        chk("t4 retry r108", retry, 3);
        for (int k = 4; k <= 255; k++) step(36);
        chk("t4 retry sat", retry, 255);
        chk("t4 pll_rst sat", pll_rst, 1);
        step(36);
        chk("t4 retry held", retry, 255);
        chk("t4 pll_rst held", pll_rst, 1);
        chk("t4 dom held", dom, 3'b111);
`else
        step(3);
        chk("t5 pll_rst r3", pll_rst, 1);
        step(1);
        chk("t5 pll_rst r4", pll_rst, 0);
        for (int k = 0; k < 4; k++) begin
            step(50);
            chk("t5 pll_rst idle", pll_rst, 0);
            chk("t5 retry idle", retry, 0);
            chk("t5 dom idle", dom, 3'b111);
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
